axi_rd_arb: RTL and testbench
=============================

Name: axi_rd_arb

Overview:
- Arbitrates the single AXI read path (AR/R) between the instruction-cache and data-cache refill/uncached read requesters.
- Keeps at most one read outstanding, steers R beats to the granted client, and drives read_unfinish to the write-buffer engine so reads and writes stay ordered.
- Blocks any read whose line matches a line still held in the write buffer (read-after-write hazard).
- Sits beside axi_wr under the top-level AXI bridge.

Parameters:
BYTES_PER_LINE, 16, cache line size in bytes, shared by both caches
WORDS_PER_LINE, BYTES_PER_LINE/4, beats per burst; AXI arlen for a burst = WORDS_PER_LINE-1
OFFSET_WIDTH, $clog2(BYTES_PER_LINE), low address bits ignored by the line-hazard compare

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
i_rd_req  in  1  inst read request; held until i_rd_rdy
i_rd_addr  in  32  inst read address
i_rd_burst  in  1  1 = full-line burst, 0 = single beat
i_rd_size  in  2  AXI size for single beat
i_rd_rdy  out  1  request accepted this cycle
i_ret_valid  out  1  return beat valid
i_ret_last  out  1  last return beat
i_ret_data  out  32  return data
d_rd_req, d_rd_addr, d_rd_burst, d_rd_size, d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data  same as i_* for the data cache
wr_idle  in  1  write buffer empty (from axi_wr)
wr_addr  in  32  address held in write buffer
read_unfinish  out  1  a read is accepted and not yet completed
arid  out  4, araddr  out  32, arlen  out  8, arsize  out  3, arburst  out  2, arlock  out  2, arcache  out  4, arprot  out  3, arvalid  out  1, arready  in  1  AXI AR channel
rid  in  4, rdata  in  32, rresp  in  2, rlast  in  1, rvalid  in  1, rready  out  1  AXI R channel

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- States: IDLE, AR, R. Reset puts the block in IDLE; every valid/rdy output is 0 after reset.
- Hazard rule, per client x: blk_x = ~wr_idle & (x_rd_addr[31:OFFSET_WIDTH] == wr_addr[31:OFFSET_WIDTH]).
- Eligibility: elig_x = x_rd_req & ~blk_x.
- Arbitration (IDLE only): fixed priority, data over inst.
  - gnt_d = elig_d; gnt_i = elig_i & ~elig_d.
  - A blocked data request does not block an eligible inst request.
- Accept: x_rd_rdy = state==IDLE & gnt_x, combinational, same cycle.
  - On accept, register addr, burst, size and owner (0 = inst, 1 = data); next state is AR.
- AR state: arvalid = 1 with stable registered fields.
  - arid = owner.
  - araddr = registered addr.
  - burst: arlen = WORDS_PER_LINE-1, arsize = 3'd2, arburst = INCR.
  - single: arlen = 0, arsize = {1'b0, size}, arburst = INCR.
  - arlock, arcache, arprot = 0.
  - arready & arvalid moves to R; otherwise stay in AR.
- R state: rready = 1.
  - owner's ret_valid = rvalid; ret_data = rdata; ret_last = rlast.
  - The other client's ret_valid stays 0.
  - rvalid & rlast moves to IDLE.
  - Beats are not counted; rlast is trusted. rid and rresp are ignored.
- read_unfinish = (state != IDLE).
  - Goes high the cycle after accept, low the cycle after the last beat.
- Latency: request to arvalid is 1 cycle; last beat to the next possible accept is 1 cycle (IDLE).
- Simultaneous events:
  - Both requests eligible in IDLE: data wins; inst stays pending.
  - wr_idle falling in the same cycle as an accept: the hazard compare uses current-cycle values.
  - New requests arriving during AR or R are not accepted (rdy = 0).
- Reset mid-transfer: returns to IDLE and drops arvalid, rready and ret_valid next cycle. The system resets the AXI slave together with this block.

Decomposition:
- Shared package/header: AXI burst encodings (BURST_FIXED, BURST_INCR), state encodings, line-size constants. These are the same ones axi_wr uses.
- One natural sub-module: a 2-port fixed-priority arbiter, reused later for write arbitration. Name: prio_arb_2.
- The state-next mux uses the existing one-hot mux_1h.

Test Plan:
1. Inst burst, no write pending: i_rd_req, addr 0x1fc00010, burst=1; arready after 2 cycles → arlen=3, arsize=2, arid=0; 4 beats 0xA..0xD to i_ret_*, i_ret_last on beat 4; read_unfinish high throughout; d_ret_valid=0.
2. Same-cycle contention: i and d request in the same IDLE cycle → d_rd_rdy=1, i_rd_rdy=0; inst is accepted the cycle after data's rlast returns to IDLE.
3. Read-after-write hazard: wr_idle=0, wr_addr=0x80000104, d_rd_addr=0x8000010c → d not accepted. Drop wr_idle → accepted next cycle.
4. Hazard bypass: d request blocked as in 3, plus an i request to 0x80000200 → inst granted while data waits.
5. Uncached single read: d burst=0, size=1, addr 0xbfaf0002 → arlen=0, arsize=1, one beat with d_ret_last=1, back to IDLE.
6. Reset mid-R after beat 2 of 4 → next cycle rready=0, read_unfinish=0, state IDLE; a new request is accepted normally.

Source files
------------

// File: rtl/axi_rd_arb_pkg.sv
// Shared constants and types for the AXI read/write bridge blocks.
package axi_rd_arb_pkg;

  localparam int unsigned DEF_BYTES_PER_LINE = 16;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } rd_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } rd_owner_t;

endpackage

// File: rtl/axi_rd_arb_prio_arb_2.sv
// Two-port fixed-priority arbiter: the high port always wins.
module prio_arb_2 (
  input  logic req_hi,
  input  logic req_lo,
  output logic gnt_hi,
  output logic gnt_lo
);

  // Low port is granted only when the high port is not requesting.
  always_comb begin
    gnt_hi = req_hi;
    gnt_lo = req_lo & ~req_hi;
  end

endmodule

// File: rtl/mux_1h.sv
// Generic one-hot multiplexer: ORs together the inputs whose select bit is set.
module mux_1h #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned N     = 2
) (
  input  logic [N-1:0]       sel,
  input  logic [N*WIDTH-1:0] din,
  output logic [WIDTH-1:0]   dout
);

  // AND-OR selection; an all-zero select yields zero.
  always_comb begin
    dout = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (sel[k]) begin
        dout = dout | din[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/axi_rd_arb.sv
// AXI read-path arbiter between instruction and data cache requesters.
// One read outstanding at a time; reads hitting a line still held in the
// write buffer are held off until the buffer drains.
module axi_rd_arb
  import axi_rd_arb_pkg::*;
#(
  parameter int unsigned BYTES_PER_LINE = axi_rd_arb_pkg::DEF_BYTES_PER_LINE
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        i_rd_req,
  input  logic [31:0] i_rd_addr,
  input  logic        i_rd_burst,
  input  logic [1:0]  i_rd_size,
  output logic        i_rd_rdy,
  output logic        i_ret_valid,
  output logic        i_ret_last,
  output logic [31:0] i_ret_data,

  input  logic        d_rd_req,
  input  logic [31:0] d_rd_addr,
  input  logic        d_rd_burst,
  input  logic [1:0]  d_rd_size,
  output logic        d_rd_rdy,
  output logic        d_ret_valid,
  output logic        d_ret_last,
  output logic [31:0] d_ret_data,

  input  logic        wr_idle,
  input  logic [31:0] wr_addr,
  output logic        read_unfinish,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int unsigned WORDS_PER_LINE = BYTES_PER_LINE / 4;
  localparam int unsigned OFFSET_WIDTH   = $clog2(BYTES_PER_LINE);
  localparam logic [7:0]  BURST_ARLEN    = 8'(WORDS_PER_LINE - 1);
  localparam int unsigned ST_W           = $bits(rd_state_t);

  rd_state_t   state;
  rd_state_t   state_next;
  rd_state_t   idle_next;
  rd_state_t   ar_next;
  rd_state_t   r_next;
  logic [ST_W-1:0] state_mux;

  logic [31:0] r_addr;
  logic        r_burst;
  logic [1:0]  r_size;
  rd_owner_t   r_owner;

  logic        blk_i;
  logic        blk_d;
  logic        elig_i;
  logic        elig_d;
  logic        gnt_i;
  logic        gnt_d;
  logic        accept;

  // rid/rresp are not used: one read outstanding, errors are not reported.
  logic        unused_rd;
  assign unused_rd = ^{rid, rresp, wr_addr[OFFSET_WIDTH-1:0]};

  // Line-granular read-after-write hazard and request eligibility.
  always_comb begin
    blk_i  = ~wr_idle & (i_rd_addr[31:OFFSET_WIDTH] == wr_addr[31:OFFSET_WIDTH]);
    blk_d  = ~wr_idle & (d_rd_addr[31:OFFSET_WIDTH] == wr_addr[31:OFFSET_WIDTH]);
    elig_i = i_rd_req & ~blk_i;
    elig_d = d_rd_req & ~blk_d;
  end

  // Data cache has fixed priority over instruction cache.
  prio_arb_2 u_arb (
    .req_hi (elig_d),
    .req_lo (elig_i),
    .gnt_hi (gnt_d),
    .gnt_lo (gnt_i)
  );

  // Same-cycle accept, only while idle.
  always_comb begin
    i_rd_rdy = (state == ST_IDLE) & gnt_i;
    d_rd_rdy = (state == ST_IDLE) & gnt_d;
    accept   = i_rd_rdy | d_rd_rdy;
  end

  // Per-state successor candidates, selected one-hot by the current state.
  always_comb begin
    idle_next = accept ? ST_AR : ST_IDLE;
    ar_next   = arready ? ST_R : ST_AR;
    r_next    = (rvalid & rlast) ? ST_IDLE : ST_R;
  end

  // An unreachable encoding selects nothing and so falls back to IDLE.
  mux_1h #(
    .WIDTH (ST_W),
    .N     (3)
  ) u_state_mux (
    .sel  ({state == ST_R, state == ST_AR, state == ST_IDLE}),
    .din  ({r_next, ar_next, idle_next}),
    .dout (state_mux)
  );

  // Cast the muxed encoding back to the state type.
  always_comb begin
    state_next = rd_state_t'(state_mux);
  end

  // State register and request capture on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      r_addr  <= '0;
      r_burst <= 1'b0;
      r_size  <= '0;
      r_owner <= OWN_INST;
    end else begin
      state <= state_next;
      if (accept) begin
        r_addr  <= gnt_d ? d_rd_addr  : i_rd_addr;
        r_burst <= gnt_d ? d_rd_burst : i_rd_burst;
        r_size  <= gnt_d ? d_rd_size  : i_rd_size;
        r_owner <= gnt_d ? OWN_DATA   : OWN_INST;
      end
    end
  end

  // AR channel driven from registered request fields.
  always_comb begin
    arvalid = (state == ST_AR);
    arid    = {3'b000, r_owner};
    araddr  = r_addr;
    arlen   = r_burst ? BURST_ARLEN : 8'd0;
    arsize  = r_burst ? SIZE_WORD : {1'b0, r_size};
    arburst = BURST_INCR;
    arlock  = '0;
    arcache = '0;
    arprot  = '0;
  end

  // R channel steered to the owning client; the other client sees nothing.
  always_comb begin
    rready        = (state == ST_R);
    read_unfinish = (state != ST_IDLE);
    i_ret_valid   = rready & rvalid & (r_owner == OWN_INST);
    d_ret_valid   = rready & rvalid & (r_owner == OWN_DATA);
    i_ret_last    = i_ret_valid & rlast;
    d_ret_last    = d_ret_valid & rlast;
    i_ret_data    = rdata;
    d_ret_data    = rdata;
  end

endmodule

// File: tb/tb_axi_rd_arb.sv
module tb_axi_rd_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_rd_req, i_rd_burst, i_rd_rdy, i_ret_valid, i_ret_last;
  logic [31:0] i_rd_addr, i_ret_data;
  logic [1:0]  i_rd_size;
  logic        d_rd_req, d_rd_burst, d_rd_rdy, d_ret_valid, d_ret_last;
  logic [31:0] d_rd_addr, d_ret_data;
  logic [1:0]  d_rd_size;
  logic        wr_idle, read_unfinish;
  logic [31:0] wr_addr;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int tests_run = 0;
  int fails = 0;

  axi_rd_arb dut (
    .clk(clk), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_burst(i_rd_burst), .i_rd_size(i_rd_size),
    .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_burst(d_rd_burst), .d_rd_size(d_rd_size),
    .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .wr_idle(wr_idle), .wr_addr(wr_addr), .read_unfinish(read_unfinish),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  // Return-beat scoreboard: every visible beat must match the oldest expected one.
  always @(negedge clk) begin
    beat_t e;
    logic [31:0] od;
    if (!reset && (i_ret_valid || d_ret_valid)) begin
      tests_run++;
      od = d_ret_valid ? d_ret_data : i_ret_data;
      if (i_ret_valid && d_ret_valid) begin
        fails++;
        $display("FAIL ret_both_valid: got i=%b d=%b required one-hot", i_ret_valid, d_ret_valid);
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL ret_unexpected: got owner=%b data=%h required no beat", d_ret_valid, od);
      end else begin
        e = exp_q.pop_front();
        if ({d_ret_valid, od, d_ret_valid ? d_ret_last : i_ret_last} !== e) begin
          fails++;
          $display("FAIL ret_beat: got owner=%b data=%h last=%b required owner=%b data=%h last=%b",
                   d_ret_valid, od, d_ret_valid ? d_ret_last : i_ret_last, e.owner, e.data, e.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Slave AR side: wait (bounded) for arvalid, hold arready low for delay cycles, then accept.
  task automatic do_ar(input int delay, output bit ok, output logic [3:0] id,
                       output logic [31:0] addr, output logic [7:0] len,
                       output logic [2:0] size, output logic [1:0] burst, output logic misc);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (arvalid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      for (int c = 0; c < delay; c++) begin
        tick();
        if (arvalid !== 1'b1) ok = 1'b0;
      end
      arready = 1'b1;
      id = arid; addr = araddr; len = arlen; size = arsize; burst = arburst;
      misc = |{arlock, arcache, arprot};
      tick();
      arready = 1'b0;
    end
  endtask

  // Slave R side: n beats of base+k, expectations pushed as each beat is driven.
  task automatic do_r(input logic owner, input int n, input logic [31:0] base, input bit end_burst,
                      output int ru_low, output int rdy_seen);
    beat_t b;
    ru_low = 0;
    rdy_seen = 0;
    for (int k = 0; k < n; k++) begin
      rvalid = 1'b1;
      rdata  = base + 32'(k);
      rlast  = end_burst && (k == n - 1);
      b.owner = owner; b.data = rdata; b.last = rlast;
      exp_q.push_back(b);
      #1;
      if (read_unfinish !== 1'b1) ru_low++;
      if (i_rd_rdy !== 1'b0 || d_rd_rdy !== 1'b0) rdy_seen++;
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if ({i_rd_rdy, d_rd_rdy, i_ret_valid, d_ret_valid, arvalid, rready, read_unfinish} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {i_rd_rdy, d_rd_rdy, i_ret_valid, d_ret_valid, arvalid, rready, read_unfinish});
    end
  endtask

  task automatic test_inst_burst();
    bit ok; logic [3:0] id; logic [31:0] a; logic [7:0] len; logic [2:0] sz; logic [1:0] bu; logic misc;
    int rl, rs;
    tick();
    i_rd_req = 1'b1; i_rd_addr = 32'h1fc00010; i_rd_burst = 1'b1; i_rd_size = 2'd2;
    #1;
    tests_run++;
    if ({i_rd_rdy, d_rd_rdy} !== 2'b10) begin
      fails++; $display("FAIL ib_accept: got %b required 10", {i_rd_rdy, d_rd_rdy});
    end
    tick();
    i_rd_req = 1'b0;
    #1;
    tests_run++;
    if ({arvalid, read_unfinish} !== 2'b11) begin
      fails++; $display("FAIL ib_ar_latency: got %b required 11", {arvalid, read_unfinish});
    end
    do_ar(2, ok, id, a, len, sz, bu, misc);
    tests_run++;
    if (!ok || {id, a, len, sz, bu, misc} !== {4'd0, 32'h1fc00010, 8'd3, 3'd2, 2'b01, 1'b0}) begin
      fails++;
      $display("FAIL ib_ar_fields: got ok=%b id=%h addr=%h len=%h size=%h burst=%h misc=%b required ok=1 id=0 addr=1fc00010 len=3 size=2 burst=1 misc=0",
               ok, id, a, len, sz, bu, misc);
    end
    do_r(1'b0, 4, 32'hA, 1'b1, rl, rs);
    #1;
    tests_run++;
    if (rl != 0 || rs != 0 || exp_q.size() != 0 || {read_unfinish, rready} !== 2'b00) begin
      fails++;
      $display("FAIL ib_complete: got ru_low=%0d rdy=%0d pending=%0d ru=%b rready=%b required 0 0 0 0 0",
               rl, rs, exp_q.size(), read_unfinish, rready);
    end
  endtask

  task automatic test_contention();
    bit ok; logic [3:0] id; logic [31:0] a; logic [7:0] len; logic [2:0] sz; logic [1:0] bu; logic misc;
    int rl, rs;
    d_rd_req = 1'b1; d_rd_addr = 32'h00001000; d_rd_burst = 1'b1; d_rd_size = 2'd2;
    i_rd_req = 1'b1; i_rd_addr = 32'h00002000; i_rd_burst = 1'b0; i_rd_size = 2'd2;
    #1;
    tests_run++;
    if ({d_rd_rdy, i_rd_rdy} !== 2'b10) begin
      fails++; $display("FAIL ct_priority: got d,i=%b required 10", {d_rd_rdy, i_rd_rdy});
    end
    tick();
    d_rd_req = 1'b0;
    do_ar(0, ok, id, a, len, sz, bu, misc);
    tests_run++;
    if (!ok || id !== 4'd1 || a !== 32'h00001000) begin
      fails++; $display("FAIL ct_d_ar: got ok=%b id=%h addr=%h required 1 1 00001000", ok, id, a);
    end
    do_r(1'b1, 4, 32'h100, 1'b1, rl, rs);
    #1;
    tests_run++;
    if (rs != 0 || i_rd_rdy !== 1'b1) begin
      fails++; $display("FAIL ct_i_after_d: got rdy_during=%0d i_rd_rdy=%b required 0 1", rs, i_rd_rdy);
    end
    tick();
    i_rd_req = 1'b0;
    do_ar(1, ok, id, a, len, sz, bu, misc);
    tests_run++;
    if (!ok || {id, a, len, sz} !== {4'd0, 32'h00002000, 8'd0, 3'd2}) begin
      fails++; $display("FAIL ct_i_ar: got ok=%b id=%h addr=%h len=%h size=%h required 1 0 00002000 0 2",
                        ok, id, a, len, sz);
    end
    do_r(1'b0, 1, 32'h200, 1'b1, rl, rs);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL ct_drain: got pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_hazard();
    bit ok; logic [3:0] id; logic [31:0] a; logic [7:0] len; logic [2:0] sz; logic [1:0] bu; logic misc;
    int rl, rs, bad;
    bad = 0;
    wr_idle = 1'b0; wr_addr = 32'h80000104;
    d_rd_req = 1'b1; d_rd_addr = 32'h8000010c; d_rd_burst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (d_rd_rdy !== 1'b0 || arvalid !== 1'b0) bad++;
      tick();
    end
    tests_run++;
    if (bad != 0) begin
      fails++; $display("FAIL hz_blocked: got %0d accepting cycles required 0", bad);
    end
    wr_idle = 1'b1;
    #1;
    tests_run++;
    if (d_rd_rdy !== 1'b1) begin
      fails++; $display("FAIL hz_release: got %b required 1", d_rd_rdy);
    end
    tick();
    d_rd_req = 1'b0;
    do_ar(0, ok, id, a, len, sz, bu, misc);
    tests_run++;
    if (!ok || {id, a, len} !== {4'd1, 32'h8000010c, 8'd3}) begin
      fails++; $display("FAIL hz_ar: got ok=%b id=%h addr=%h len=%h required 1 1 8000010c 3", ok, id, a, len);
    end
    do_r(1'b1, 4, 32'h300, 1'b1, rl, rs);
  endtask

  task automatic test_hazard_bypass();
    bit ok; logic [3:0] id; logic [31:0] a; logic [7:0] len; logic [2:0] sz; logic [1:0] bu; logic misc;
    int rl, rs;
    wr_idle = 1'b0; wr_addr = 32'h80000104;
    d_rd_req = 1'b1; d_rd_addr = 32'h80000100; d_rd_burst = 1'b1;
    i_rd_req = 1'b1; i_rd_addr = 32'h80000200; i_rd_burst = 1'b1;
    #1;
    tests_run++;
    if ({d_rd_rdy, i_rd_rdy} !== 2'b01) begin
      fails++; $display("FAIL hb_grant: got d,i=%b required 01", {d_rd_rdy, i_rd_rdy});
    end
    tick();
    i_rd_req = 1'b0;
    do_ar(0, ok, id, a, len, sz, bu, misc);
    tests_run++;
    if (!ok || {id, a} !== {4'd0, 32'h80000200}) begin
      fails++; $display("FAIL hb_i_ar: got ok=%b id=%h addr=%h required 1 0 80000200", ok, id, a);
    end
    do_r(1'b0, 4, 32'h400, 1'b1, rl, rs);
    #1;
    tests_run++;
    if (d_rd_rdy !== 1'b0) begin
      fails++; $display("FAIL hb_d_still_blocked: got %b required 0", d_rd_rdy);
    end
    wr_idle = 1'b1;
    #1;
    tests_run++;
    if (d_rd_rdy !== 1'b1) begin
      fails++; $display("FAIL hb_d_release: got %b required 1", d_rd_rdy);
    end
    tick();
    d_rd_req = 1'b0;
    do_ar(0, ok, id, a, len, sz, bu, misc);
    do_r(1'b1, 4, 32'h500, 1'b1, rl, rs);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL hb_drain: got pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_single();
    bit ok; logic [3:0] id; logic [31:0] a; logic [7:0] len; logic [2:0] sz; logic [1:0] bu; logic misc;
    int rl, rs;
    d_rd_req = 1'b1; d_rd_addr = 32'hbfaf0002; d_rd_burst = 1'b0; d_rd_size = 2'd1;
    tick();
    d_rd_req = 1'b0;
    do_ar(0, ok, id, a, len, sz, bu, misc);
    tests_run++;
    if (!ok || {id, a, len, sz, bu, misc} !== {4'd1, 32'hbfaf0002, 8'd0, 3'd1, 2'b01, 1'b0}) begin
      fails++;
      $display("FAIL sg_ar_fields: got ok=%b id=%h addr=%h len=%h size=%h burst=%h misc=%b required 1 1 bfaf0002 0 1 1 0",
               ok, id, a, len, sz, bu, misc);
    end
    do_r(1'b1, 1, 32'h55, 1'b1, rl, rs);
    #1;
    tests_run++;
    if (exp_q.size() != 0 || read_unfinish !== 1'b0 || rready !== 1'b0) begin
      fails++; $display("FAIL sg_idle: got pending=%0d ru=%b rready=%b required 0 0 0",
                        exp_q.size(), read_unfinish, rready);
    end
  endtask

  task automatic test_reset_mid_r();
    bit ok; logic [3:0] id; logic [31:0] a; logic [7:0] len; logic [2:0] sz; logic [1:0] bu; logic misc;
    int rl, rs;
    i_rd_req = 1'b1; i_rd_addr = 32'h1fc00040; i_rd_burst = 1'b1;
    tick();
    i_rd_req = 1'b0;
    do_ar(0, ok, id, a, len, sz, bu, misc);
    do_r(1'b0, 2, 32'h600, 1'b0, rl, rs);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if ({rready, read_unfinish, arvalid, i_ret_valid} !== 4'b0000 || exp_q.size() != 0) begin
      fails++; $display("FAIL rm_reset: got rready,ru,arvalid,ivalid=%b pending=%0d required 0000 0",
                        {rready, read_unfinish, arvalid, i_ret_valid}, exp_q.size());
    end
    d_rd_req = 1'b1; d_rd_addr = 32'h00003000; d_rd_burst = 1'b0; d_rd_size = 2'd2;
    #1;
    tests_run++;
    if (d_rd_rdy !== 1'b1) begin
      fails++; $display("FAIL rm_new_accept: got %b required 1", d_rd_rdy);
    end
    tick();
    d_rd_req = 1'b0;
    do_ar(0, ok, id, a, len, sz, bu, misc);
    tests_run++;
    if (!ok || {id, a} !== {4'd1, 32'h00003000}) begin
      fails++; $display("FAIL rm_ar: got ok=%b id=%h addr=%h required 1 1 00003000", ok, id, a);
    end
    do_r(1'b1, 1, 32'h700, 1'b1, rl, rs);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL rm_drain: got pending=%0d required 0", exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    i_rd_req = 1'b0; i_rd_addr = '0; i_rd_burst = 1'b0; i_rd_size = '0;
    d_rd_req = 1'b0; d_rd_addr = '0; d_rd_burst = 1'b0; d_rd_size = '0;
    wr_idle = 1'b1; wr_addr = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    test_reset();
    test_inst_burst();
    test_contention();
    test_hazard();
    test_hazard_bypass();
    test_single();
    test_reset_mid_r();
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
